// File: rtl/gpio_debounce.sv
// Pushbutton conditioner: 2-flop sync, per-channel debounce, edge pulses, sticky events.
// Edge pulses, events and ack logic exist only when GPIO_DEBOUNCE_EVENT_EN is defined.
module gpio_debounce #(
  parameter int              NumIn          = 3,
  parameter int              DebounceCycles = 6000,
  parameter logic [NumIn-1:0] ResetValue    = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumIn-1:0] pin_i,
  output logic [NumIn-1:0] level_o,
  output logic [NumIn-1:0] rise_o,
  output logic [NumIn-1:0] fall_o,
  output logic [NumIn-1:0] event_o,
  input  logic [NumIn-1:0] ack_i
);

  localparam int CW = $clog2(DebounceCycles);
  localparam logic [CW-1:0] CntMax = CW'(DebounceCycles - 1);

  logic [NumIn-1:0] meta_q;
  logic [NumIn-1:0] sync_q;
  logic [NumIn-1:0] level_q;
  logic [NumIn-1:0] accept;
  logic [CW-1:0]    cnt_q [NumIn];
  logic [CW-1:0]    cnt_d [NumIn];

  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      accept[i] = 1'b0;
      cnt_d[i]  = '0;
      if (sync_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          accept[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= ResetValue;
      sync_q  <= ResetValue;
      level_q <= ResetValue;
      for (int i = 0; i < NumIn; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      meta_q  <= pin_i;
      sync_q  <= meta_q;
      level_q <= level_q ^ accept;
      for (int i = 0; i < NumIn; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign level_o = level_q;

`ifdef GPIO_DEBOUNCE_EVENT_EN
  logic [NumIn-1:0] rise_q;
  logic [NumIn-1:0] fall_q;
  logic [NumIn-1:0] event_q;

  // A showing pulse holds the flag so an ack in that cycle cannot clear it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= '0;
    end else begin
      rise_q  <= accept & sync_q;
      fall_q  <= accept & ~sync_q;
      event_q <= accept | rise_q | fall_q | (event_q & ~ack_i);
    end
  end

  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = event_q;
`else
  logic unused_ack;
  assign unused_ack = ^ack_i;
  assign rise_o     = '0;
  assign fall_o     = '0;
  assign event_o    = '0;
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: directed scenarios plus random pin traffic vs a window model.
// Expects edge/event outputs only when GPIO_DEBOUNCE_EVENT_EN is defined.
module tb_gpio_debounce;

  localparam int D = 4;
`ifdef GPIO_DEBOUNCE_EVENT_EN
  localparam bit EvEn = 1'b1;
`else
  localparam bit EvEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [2:0] pin;
  logic [2:0] ack;
  logic [2:0] level;
  logic [2:0] rise;
  logic [2:0] fall;
  logic [2:0] ev;

  int checks = 0;
  int failures = 0;

  logic [2:0] m_level;
  logic [2:0] m_rise;
  logic [2:0] m_fall;
  logic [2:0] m_ev;
  logic [2:0] hist[$];

  gpio_debounce #(
    .NumIn(3),
    .DebounceCycles(D),
    .ResetValue(3'b000)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .pin_i(pin),
    .level_o(level),
    .rise_o(rise),
    .fall_o(fall),
    .event_o(ev),
    .ack_i(ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int j = 0; j < D + 2; j++) hist.push_back(3'b000);
    m_level = 3'b000;
    m_rise  = 3'b000;
    m_fall  = 3'b000;
    m_ev    = 3'b000;
  endtask

  // A level flips when the D pin samples that reached the sync
  // output before this edge all disagree with the current level.
  task automatic model_edge(input logic [2:0] p, input logic [2:0] a);
    logic [2:0] acc;
    logic [2:0] prev_pulse;
    prev_pulse = m_rise | m_fall;
    hist.push_back(p);
    acc = 3'b111;
    for (int j = 2; j < D + 2; j++)
      acc &= hist[hist.size() - 1 - j] ^ m_level;
    m_level ^= acc;
    m_rise = EvEn ? (acc & m_level) : 3'b000;
    m_fall = EvEn ? (acc & ~m_level) : 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (m_rise[i] || m_fall[i]) m_ev[i] = 1'b1;
      else if (a[i] && !prev_pulse[i]) m_ev[i] = 1'b0;
    end
    if (!EvEn) m_ev = 3'b000;
    while (hist.size() > 16) void'(hist.pop_front());
  endtask

  task automatic tick(input logic [2:0] p, input logic [2:0] a);
    @(negedge clk);
    pin = p;
    ack = a;
    @(posedge clk);
    model_edge(p, a);
    #1;
    chk("model_level", 32'(level), 32'(m_level));
    chk("model_rise", 32'(rise), 32'(m_rise));
    chk("model_fall", 32'(fall), 32'(m_fall));
    chk("model_event", 32'(ev), 32'(m_ev));
  endtask

  initial begin
    logic [2:0] rp;
    int         hold [3];
    rst_ni = 1'b0;
    pin    = 3'b000;
    ack    = 3'b000;
    model_reset();
    #1;
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_rise", 32'(rise), 32'h0);
    chk("rst_fall", 32'(fall), 32'h0);
    chk("rst_event", 32'(ev), 32'h0);
    @(posedge clk);
    #3 rst_ni = 1'b1;

    // basic press on channel 0
    for (int c = 1; c <= 5; c++) tick(3'b001, 3'b000);
    chk("press_early", 32'(level[0]), 32'h0);
    tick(3'b001, 3'b000);
    chk("press_level", 32'(level[0]), 32'h1);
    chk("press_rise", 32'(rise[0]), 32'(EvEn));
    tick(3'b001, 3'b000);
    chk("press_rise_end", 32'(rise[0]), 32'h0);
    chk("press_event", 32'(ev[0]), 32'(EvEn));

    // glitch on channel 1
    for (int c = 0; c < 3; c++) tick(3'b011, 3'b000);
    for (int c = 0; c < 8; c++) begin
      tick(3'b001, 3'b000);
      chk("glitch_level", 32'(level[1]), 32'h0);
      chk("glitch_event", 32'(ev[1]), 32'h0);
    end

    // release channel 0
    for (int c = 1; c <= 10; c++) begin
      tick(3'b000, 3'b000);
      if (c == 6) begin
        chk("release_fall", 32'(fall[0]), 32'(EvEn));
        chk("release_level", 32'(level[0]), 32'h0);
      end
    end
    tick(3'b000, 3'b001);
    chk("ack_clear0", 32'(ev[0]), 32'h0);

    // ack collides with rise on channel 2
    for (int c = 0; c < 6; c++) tick(3'b100, 3'b000);
    chk("coll_rise", 32'(rise[2]), 32'(EvEn));
    tick(3'b100, 3'b100);
    chk("coll_hold", 32'(ev[2]), 32'(EvEn));
    tick(3'b100, 3'b100);
    chk("coll_clear", 32'(ev[2]), 32'h0);

    // async reset two cycles into a press on channel 0
    tick(3'b101, 3'b000);
    tick(3'b101, 3'b000);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_level", 32'(level), 32'h0);
    chk("midrst_edges", 32'({rise, fall}), 32'h0);
    chk("midrst_event", 32'(ev), 32'h0);
    model_reset();
    @(posedge clk);
    #3 rst_ni = 1'b1;
    for (int c = 1; c <= 5; c++) tick(3'b101, 3'b000);
    chk("postrst_early", 32'(level), 32'h0);
    tick(3'b101, 3'b000);
    chk("postrst_level", 32'(level), 32'h5);
    chk("postrst_rise", 32'(rise), EvEn ? 32'h5 : 32'h0);

    // random traffic
    rp = 3'b101;
    for (int i = 0; i < 3; i++) hold[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          rp[i] = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 8));
        end
        hold[i]--;
      end
      tick(rp, ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_debounce.md
# gpio_debounce

Input conditioner for raw board pushbuttons feeding the SoC GPIO inputs (`gpio_i`) on FPGA builds. Each channel is brought into the `clk_i` domain with a two-flop synchronizer and then debounced with a per-channel stability counter. The block outputs clean levels plus single-cycle rise/fall pulses and sticky, software-acknowledged event flags. It is the input-side counterpart to the GPIO-to-LED output path and sits between the board pins and the SoC.

## Interface
- `NumIn`, default 3: number of input channels.
- `DebounceCycles`, default 6000: cycles an input must hold a new value before it is accepted (1 ms at 6 MHz). Legal range is ≥ 2.
- `ResetValue`, default `'0`: reset value of `level_o`, `NumIn` bits.
- `clk_i`  input  1  single clock for the whole block.
- `rst_ni`  input  1  reset; asynchronous, active-low.
- `pin_i`  input  NumIn  raw, asynchronous button levels.
- `level_o`  output  NumIn  debounced level per channel.
- `rise_o`  output  NumIn  one-cycle pulse on an accepted 0→1 transition.
- `fall_o`  output  NumIn  one-cycle pulse on an accepted 1→0 transition.
- `event_o`  output  NumIn  sticky flag, set by any accepted transition.
- `ack_i`  input  NumIn  write-one-to-clear for `event_o`, sampled every cycle.

## Operation
- Synchronizer per channel: `pin_i` → `meta_q` → `sync_q`, no reset dependence on the pin value. Both flops reset to `ResetValue`.
- Counter per channel is `$clog2(DebounceCycles)` bits wide, unsigned, and resets to 0.
  - If `sync_q == level_o`: the counter clears to 0.
  - If `sync_q != level_o` and `cnt < DebounceCycles-1`: the counter increments.
  - If `sync_q != level_o` and `cnt == DebounceCycles-1`: `level_o <= sync_q`, the counter clears, and a pulse is issued (`rise_o` if the new level is 1, `fall_o` if it is 0).
- Any return of `sync_q` to `level_o` before acceptance clears the counter. Glitches shorter than `DebounceCycles` cycles produce no output change. The counter never wraps.
- `rise_o` and `fall_o` are registered. Each is high only in the cycle where the new `level_o` first appears, and they are never both high on one channel.
- `event_o[n]`:
  - Set in the same cycle as `rise_o[n]` or `fall_o[n]`.
  - Cleared the cycle after `ack_i[n]` = 1.
  - If set and ack occur in the same cycle, set wins and the flag stays 1.
- Channels are fully independent. Simultaneous transitions on several channels are each handled in parallel.

## Timing
- Reset values: `level_o` = `ResetValue`; `rise_o`, `fall_o` and `event_o` = 0.
- Reset is asynchronous and clears all state mid-count. After release, debouncing restarts from count 0 against `ResetValue`.
- Latency: a pin change captured at clock edge k is first visible on `level_o` / `rise_o` / `fall_o` after edge k+1+`DebounceCycles`. That is `DebounceCycles`+2 cycles, including the capture edge.
- Minimum accepted pulse width on the pin is `DebounceCycles` consecutive cycles of stable synchronized value.
- `event_o` clear latency from `ack_i` is 1 cycle.

## Configuration
- Macro `GPIO_DEBOUNCE_EVENT_EN`.
- Defined: `rise_o`, `fall_o`, `event_o` and the `ack_i` logic are built as described above.
- Undefined: these outputs are tied to 0, `ack_i` is ignored, and no edge or event flops are synthesized. `level_o` behaviour is unchanged.

## Test plan
All directed tests use `DebounceCycles`=4, `NumIn`=3, `ResetValue`=0, and `GPIO_DEBOUNCE_EVENT_EN` defined.
- **Basic press:** hold `pin_i[0]` 0→1 from edge k. Required response: `level_o[0]` = 1 and `rise_o[0]` = 1 for exactly one cycle after edge k+5, and `event_o[0]` = 1 thereafter.
- **Glitch rejection:** pulse `pin_i[1]` high for 3 cycles, then low. Required response: `level_o[1]` stays 0, and no `rise_o` or `event_o` activity.
- **Release:** with `level_o[0]` = 1, drop `pin_i[0]` to 0 for 10 cycles. Required response: `fall_o[0]` pulses once, 6 cycles after the edge, and `level_o[0]` = 0.
- **Ack collision:** assert `ack_i[2]` in the same cycle as `rise_o[2]`. Required response: `event_o[2]` remains 1. Ack again one cycle later and `event_o[2]` must read 0 on the following cycle.
- **Reset mid-count:** drop `rst_ni` asynchronously 2 cycles into a press. Required response: all outputs go to 0 immediately. After release with the pin held at 1, `level_o` rises `DebounceCycles`+2 cycles later, timed from the first capture edge after release.
- **Macro off:** rebuild without `GPIO_DEBOUNCE_EVENT_EN` and rerun the basic press. Required response: `level_o` timing is identical, and `rise_o` / `fall_o` / `event_o` stay 0.
